pattern_det_arbiter: RTL and testbench
======================================

PATTERN_DET_ARBITER -- requirements
Module: pattern_det_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of serial requesters (fixed 4 in this revision).
REQ-002 SHALL have parameter CNT_W, default 8, meaning match-counter width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, meaning idle-cycle limit for the watchdog.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  4  per-channel frame request.
REQ-007 d_i  in  4  per-channel serial data bit.
REQ-008 valid_i  in  4  per-channel bit-valid.
REQ-009 last_i  in  4  per-channel last-bit-of-frame marker; meaningful only with valid_i.
REQ-010 gnt  out  4  one-hot grant, registered.
REQ-011 pattern  out  1  one-cycle match pulse.
REQ-012 pattern_ch  out  2  channel index of current or last frame.
REQ-013 frame_done  out  1  one-cycle end-of-frame pulse.
REQ-014 match_cnt  out  CNT_W  matches in current or last frame.
REQ-015 timeout  out  1  one-cycle watchdog-abort pulse.

Function
REQ-016 SHALL use controller FSM states IDLE, STREAM, DONE.
- IDLE: any req -> STREAM, gnt set next cycle.
- STREAM: accepted last bit -> DONE.
- DONE: -> IDLE after exactly 1 cycle.
REQ-017 SHALL use round-robin arbitration: search starts at channel after last granted; after reset ch0 has highest priority.
REQ-018 SHALL hold gnt constant for the whole frame; req deassertion mid-frame SHALL be ignored.
REQ-019 SHALL accept a bit only when in STREAM and valid_i of the granted channel is high; d_i/valid_i/last_i of other channels SHALL be ignored.
REQ-020 SHALL clear detector state and match_cnt on entering STREAM so matches never span frames.
REQ-021 SHALL detect overlapping pattern 0,1,1,0,1 with detector states S0..S4.
- S0: 0->S1, 1->S0.
- S1: 0->S1, 1->S2.
- S2: 0->S1, 1->S3.
- S3: 0->S4, 1->S0.
- S4: 0->S1; 1->S2 plus match.
REQ-022 SHALL register pattern high in the cycle after the bit completing a match (latency 1).
REQ-023 SHALL increment match_cnt on each match and saturate at 2^CNT_W-1.
REQ-024 SHALL pulse frame_done in the cycle after the accepted last bit, with gnt cleared in the same cycle.
- match_cnt SHALL then include any match on that last bit.
- match_cnt and pattern_ch SHALL hold until the next grant.
REQ-025 SHALL treat valid_i and last_i both high on the first bit as a one-bit frame.
REQ-026 SHALL insert at least one idle cycle between frames; back-to-back requests SHALL be granted IDLE+1 cycle later.

Reset
REQ-027 rst SHALL force, immediately and regardless of clk:
- FSM=IDLE, detector=S0, RR pointer to ch0 first;
- gnt=0, pattern=0, frame_done=0, timeout=0, match_cnt=0, pattern_ch=0.
REQ-028 rst mid-frame SHALL abort the frame without a frame_done pulse.

Configuration
REQ-029 With PATTERN_DET_TIMEOUT_EN defined, the watchdog SHALL count consecutive STREAM cycles without an accepted bit; at TIMEOUT_CYC it SHALL abort the frame:
- timeout pulse 1 cycle;
- frame_done pulse in the same cycle;
- DONE then IDLE;
- RR pointer advances past the aborted channel.
REQ-030 Without PATTERN_DET_TIMEOUT_EN, STREAM SHALL wait indefinitely, timeout SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-031 SHALL place in shared package pattern_det_pkg:
- detector state encodings S0..S4;
- controller state encodings IDLE/STREAM/DONE;
- pattern constant 5'b01101.
REQ-032 SHALL instantiate sub-module pattern_det_core (detector FSM with clear, bit, valid inputs and match output); arbitration, counting and watchdog SHALL stay in the top module.

Verification
REQ-033 ch1 only, frame 0,1,1,0,1,1,0,1 (last on 8th bit) -> pattern pulses after bits 5 and 8, frame_done with match_cnt=2, pattern_ch=1.
REQ-034 req=4'b1111 held -> grants in order ch0,ch1,ch2,ch3,ch0, each frame one bit, one idle cycle between grants.
REQ-035 ch0 frame 0,1,1,0 with last; then ch0 frame 1 -> match_cnt=0 both frames (no cross-frame match).
REQ-036 300 repetitions of 0,1,1,0,1 overlapped -> match_cnt saturates at 255.
REQ-037 rst asserted mid-frame between clock edges -> gnt=0 immediately, no frame_done, next frame counts from 0.
REQ-038 With PATTERN_DET_TIMEOUT_EN: ch2 granted, no valid for 16 cycles -> timeout and frame_done pulse together, next grant goes to ch3 if requesting.

Source files
------------

// File: rtl/pattern_det_pkg.sv
// Shared encodings and constants for the serial pattern detector / arbiter.
// Optional feature macro: PATTERN_DET_TIMEOUT_EN (idle-frame watchdog).
package pattern_det_pkg;

    // Detector progress through the 0,1,1,0,1 sequence
    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4
    } det_state_e;

    // Frame controller states
    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } ctrl_state_e;

    // Target sequence, first bit in the MSB
    localparam logic [4:0] PATTERN = 5'b01101;

endpackage

// File: rtl/pattern_det_core.sv
// Overlapping 0,1,1,0,1 detector; match_o is combinational on the completing bit.
// Used by pattern_det_arbiter (see PATTERN_DET_TIMEOUT_EN there).
module pattern_det_core
    import pattern_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_i,
    input  logic valid_i,
    output logic match_o
);

    det_state_e state_q;
    det_state_e state_d;

    // Detector state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and match decode; clear wins so a new frame starts from S0
    always_comb begin
        state_d = state_q;
        match_o = 1'b0;
        if (clear) begin
            state_d = S0;
        end else if (valid_i) begin
            case (state_q)
                S0: state_d = bit_i ? S0 : S1;
                S1: state_d = bit_i ? S2 : S1;
                S2: state_d = bit_i ? S3 : S1;
                S3: state_d = bit_i ? S0 : S4;
                S4: begin
                    if (bit_i == PATTERN[0]) begin
                        // Suffix "0,1" of the match is a valid prefix, so resume at S2
                        state_d = S2;
                        match_o = 1'b1;
                    end else begin
                        state_d = S1;
                    end
                end
                default: state_d = S0;
            endcase
        end
    end

endmodule

// File: rtl/pattern_det_arbiter.sv
// Round-robin arbiter over serial requesters with per-frame pattern counting.
// Define PATTERN_DET_TIMEOUT_EN to enable the idle-frame watchdog abort.
module pattern_det_arbiter
    import pattern_det_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] d_i,
    input  logic [NUM_CH-1:0] valid_i,
    input  logic [NUM_CH-1:0] last_i,
    output logic [NUM_CH-1:0] gnt,
    output logic              pattern,
    output logic [1:0]        pattern_ch,
    output logic              frame_done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              timeout
);

    // Channel indexing is 2 bits wide; reject other configurations at elaboration
    if (NUM_CH != 4 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("pattern_det_arbiter supports NUM_CH=4 and TIMEOUT_CYC>0 only");
    end

    ctrl_state_e       state_q, state_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pattern_q, pattern_d;
    logic              frame_done_q, frame_done_d;

    logic [1:0] rr_idx;
    logic       rr_found;
    logic [1:0] cand;
    logic       start;
    logic       accept;
    logic       match;
    logic       wd_abort;

    // Only the granted channel's serial lane is observed
    assign accept = (state_q == STREAM) && valid_i[ch_q];

    // Round-robin pick: search begins at the channel after the last grant
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = ptr_q + 2'(i);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Controller next-state, grant and end-of-frame decode
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        ch_d         = ch_q;
        start        = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d        = STREAM;
                    gnt_d          = '0;
                    gnt_d[rr_idx]  = 1'b1;
                    ptr_d          = rr_idx;
                    ch_d           = rr_idx;
                    start          = 1'b1;
                end
            end
            STREAM: begin
                if ((accept && last_i[ch_q]) || wd_abort) begin
                    state_d      = DONE;
                    gnt_d        = '0;
                    frame_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Saturating per-frame match counter, cleared when a frame is granted
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Match pulse is registered one cycle after the completing bit
    always_comb begin
        pattern_d = match;
    end

    // Controller and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            ptr_q        <= 2'(NUM_CH - 1);
            ch_q         <= '0;
            cnt_q        <= '0;
            pattern_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            pattern_q    <= pattern_d;
            frame_done_q <= frame_done_d;
        end
    end

    pattern_det_core u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .bit_i   (d_i[ch_q]),
        .valid_i (accept),
        .match_o (match)
    );

`ifdef PATTERN_DET_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // Watchdog: consecutive STREAM cycles without an accepted bit
    always_comb begin
        wd_d     = wd_q;
        wd_abort = 1'b0;
        if (state_q != STREAM || accept) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            wd_abort = 1'b1;
            wd_d     = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
        timeout_d = wd_abort;
    end

    // Watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_abort = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign pattern    = pattern_q;
    assign pattern_ch = ch_q;
    assign frame_done = frame_done_q;
    assign match_cnt  = cnt_q;

endmodule

// File: tb/tb_pattern_det_arbiter.sv
// Self-checking bench for pattern_det_arbiter (PATTERN_DET_TIMEOUT_EN aware).
module tb_pattern_det_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req, d_i, valid_i, last_i;
    logic [3:0] gnt;
    logic       pattern;
    logic [1:0] pattern_ch;
    logic       frame_done;
    logic [7:0] match_cnt;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          ch;
        int          nbits;
        logic [15:0] bits;   // first bit in position nbits-1
        int          cnt;
    } vec_t;

    typedef struct {
        int ch;
        int cnt;
        bit to;
    } exp_t;

    exp_t sb[$];

    pattern_det_arbiter #(
        .NUM_CH      (4),
        .CNT_W       (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .d_i        (d_i),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .gnt        (gnt),
        .pattern    (pattern),
        .pattern_ch (pattern_ch),
        .frame_done (frame_done),
        .match_cnt  (match_cnt),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Random activity on every lane except the granted one
    task automatic junk(input int ch);
        for (int j = 0; j < 4; j++) begin
            if (j != ch) begin
                d_i[j]     = 1'($urandom);
                valid_i[j] = 1'($urandom);
                last_i[j]  = 1'($urandom);
            end
        end
    endtask

    task automatic run_frame(input int ch, input int nbits, input logic [15:0] bits,
                             input int reps, input int cnt);
        int         w;
        int         nb;
        int         total;
        logic [4:0] win;
        logic       b;
        logic       m;
        req     = '0;
        req[ch] = 1'b1;
        w = 0;
        while (!gnt[ch] && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("grant", gnt, 32'(1 << ch));
        if (!gnt[ch]) begin
            req = '0;
            return;
        end
        req = '0;
        sb.push_back('{ch, cnt, 1'b0});
        win   = '0;
        nb    = 0;
        total = nbits * reps;
        for (int k = 0; k < total; k++) begin
            if (reps == 1 && $urandom_range(0, 3) == 0) begin
                junk(ch);
                valid_i[ch] = 1'b0;
                @(posedge clk); #1;
                chk("gap_pattern", pattern, 0);
            end
            b = bits[nbits - 1 - (k % nbits)];
            junk(ch);
            d_i[ch]     = b;
            valid_i[ch] = 1'b1;
            last_i[ch]  = (k == total - 1);
            win = {win[3:0], b};
            nb++;
            m = (nb >= 5) && (win == 5'b01101);
            @(posedge clk); #1;
            chk("pattern_bit", pattern, m);
            if (k < total - 1) chk("gnt_held", gnt, 32'(1 << ch));
        end
        valid_i = '0;
        last_i  = '0;
        d_i     = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[9];
        exp_t e;
        int   w;
        int   c;
        int   seen;

        tbl[0] = '{1, 8,  16'b01101101,    2};
        tbl[1] = '{0, 4,  16'b0110,        0};
        tbl[2] = '{0, 1,  16'b1,           0};
        tbl[3] = '{2, 5,  16'b01101,       1};
        tbl[4] = '{3, 4,  16'b1111,        0};
        tbl[5] = '{2, 11, 16'b01101101101, 3};
        tbl[6] = '{0, 6,  16'b001101,      1};
        tbl[7] = '{3, 10, 16'b0110101101,  2};
        tbl[8] = '{1, 7,  16'b1101101,     1};

        rst = 1'b1; req = '0; d_i = '0; valid_i = '0; last_i = '0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!rst && frame_done) begin
                        if (sb.size() == 0) begin
                            chk("spurious_frame_done", frame_done, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("done_ch", pattern_ch, e.ch);
                            chk("done_cnt", match_cnt, e.cnt);
                            chk("done_timeout", timeout, e.to);
                            chk("done_gnt_clear", gnt, 0);
                        end
                    end
                    if (!rst && timeout && !frame_done) chk("timeout_alone", timeout, 0);
                end
            end
            begin : guard
                #2ms;
                $display("FAIL global_timeout: simulation exceeded time limit");
                $fatal(1, "time limit");
            end
        join_none

        #23;
        chk("rst_gnt", gnt, 0);
        chk("rst_pattern", pattern, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_pattern_ch", pattern_ch, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) run_frame(tbl[i].ch, tbl[i].nbits, tbl[i].bits, 1, tbl[i].cnt);

        // 300 overlapped repetitions saturate the 8-bit counter
        run_frame(0, 5, 16'b01101, 300, 255);

`ifdef PATTERN_DET_TIMEOUT_EN
        req = 4'b0100;
        w = 0;
        while (!gnt[2] && w < 20) begin @(posedge clk); #1; w++; end
        chk("wd_grant_ch2", gnt, 4'b0100);
        req = 4'b1100;
        sb.push_back('{2, 0, 1'b1});
        c = 0;
        while (!frame_done && c < 40) begin @(posedge clk); #1; c++; end
        chk("wd_latency", c, 16);
        chk("wd_timeout_pulse", timeout, 1);
        w = 0;
        while (gnt == 0 && w < 20) begin @(posedge clk); #1; w++; end
        chk("rr_after_timeout", gnt, 4'b1000);
        req = '0;
        sb.push_back('{3, 0, 1'b0});
        valid_i = 4'b1000; last_i = 4'b1000; d_i = '0;
        @(posedge clk); #1;
        valid_i = '0; last_i = '0;
        repeat (2) @(posedge clk);
        #1;
`else
        req = 4'b0100;
        w = 0;
        while (!gnt[2] && w < 20) begin @(posedge clk); #1; w++; end
        chk("stall_grant_ch2", gnt, 4'b0100);
        req = '0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (timeout || frame_done) seen++;
        end
        chk("stall_no_abort", seen, 0);
        chk("stall_gnt_held", gnt, 4'b0100);
        sb.push_back('{2, 0, 1'b0});
        valid_i = 4'b0100; last_i = 4'b0100; d_i = '0;
        @(posedge clk); #1;
        valid_i = '0; last_i = '0;
        repeat (2) @(posedge clk);
        #1;
`endif

        // Asynchronous reset mid-frame, with a match-completing bit pending
        req = 4'b0010;
        w = 0;
        while (!gnt[1] && w < 20) begin @(posedge clk); #1; w++; end
        chk("mid_rst_grant", gnt, 4'b0010);
        req = '0;
        for (int k = 0; k < 4; k++) begin
            valid_i[1] = 1'b1;
            d_i[1]     = (k == 1 || k == 2);
            @(posedge clk); #1;
        end
        d_i[1] = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_pattern_ch", pattern_ch, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        valid_i = '0; d_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // All channels requesting: rotation starts at ch0 after reset
        req = 4'hF; valid_i = 4'hF; last_i = 4'hF; d_i = '0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (gnt == 0 && w < 10) begin @(posedge clk); #1; w++; end
            if (k > 0) chk("rr_gap", w, 2);
            chk("rr_order", gnt, 32'(1 << (k % 4)));
            sb.push_back('{k % 4, 0, 1'b0});
            if (k == 4) req = '0;
            @(posedge clk); #1;
        end
        valid_i = '0; last_i = '0;
        repeat (2) @(posedge clk);
        #1;

        // Counting restarts from zero after the aborted frame
        run_frame(1, 6, 16'b011010, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
